// File: rtl/ppx_mc_pkg.sv
// ---------------------------------------------------------------------------
// ppx_mc_pkg
// Shared definitions for the multi-channel pulse-per-X generator:
//   - per-channel FSM state encoding
//   - configuration register addresses (cfg_addr values)
//   - bit positions inside the ctrl register
// ---------------------------------------------------------------------------
package ppx_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ch_state_e;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_PHASE  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_BURST  = 2'd3;

  // ctrl register layout: [5] sync_mode, [4:0] duty_log2
  localparam int DUTY_W        = 5;
  localparam int CTRL_DUTY_LSB = 0;
  localparam int CTRL_SYNC_BIT = 5;

endpackage

// File: rtl/ppx_mc_if.sv
// ---------------------------------------------------------------------------
// ppx_mc_if
// Configuration bus shared by all channels of ppx_generator_mc.
//   cfg_wr    write strobe
//   cfg_ch    target channel index (CH_W bits)
//   cfg_addr  register select (see ppx_mc_pkg ADDR_*)
//   cfg_data  write data (CNT_W bits)
// Modports: master drives the bus, slave (the generator) receives it.
// ---------------------------------------------------------------------------
interface ppx_mc_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
) ();

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_addr,
    output cfg_data
  );

  modport slave (
    input cfg_wr,
    input cfg_ch,
    input cfg_addr,
    input cfg_data
  );

endinterface

// File: rtl/ppx_mc_channel.sv
// ---------------------------------------------------------------------------
// ppx_mc_channel
// One pulse-per-X channel: staging and active configuration registers,
// IDLE/ARMED/RUN/DONE state machine, period and pulse counters, and the
// registered pulse output.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   cfg_wr           write strobe already qualified for this channel
//   cfg_addr         register select (period/phase/ctrl/burst)
//   cfg_data         write data
//   start, stop      arm/start and abort strobes
//   sync_edge        one-cycle strobe from the shared sync edge detector
//   ppx              registered pulse output
//   busy             channel is ARMED or RUN
//   done             one-cycle strobe while in DONE (burst finished)
//   pulse_cnt        pulses since last RUN entry (PPX_MC_STATUS_EN only)
//
// Configuration macro: PPX_MC_STATUS_EN exposes the pulse counter as a port.
// ---------------------------------------------------------------------------
module ppx_mc_channel
  import ppx_mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int CLK_FREQ = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             sync_edge,
  output logic             ppx,
  output logic             busy,
  output logic             done
`ifdef PPX_MC_STATUS_EN
  ,
  output logic [CNT_W-1:0] pulse_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(CLK_FREQ);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  // High-phase length minus one. duty_log2==0 or duty_log2>=CNT_W give a
  // single-cycle pulse; otherwise P>>duty_log2, never less than one cycle.
  function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0]  p,
                                                 input logic [DUTY_W-1:0] d);
    logic [CNT_W-1:0] w;
    w = ONE;
    if (d != '0 && int'(d) < CNT_W) begin
      w = p >> d;
      if (w == '0) w = ONE;
    end
    return w - ONE;
  endfunction

  // Staging registers (software view)
  logic [CNT_W-1:0]  period_q, phase_q, burst_q;
  logic [DUTY_W-1:0] duty_q;
  logic              sync_mode_q;

  // Staging values including a write in this cycle, so that a write landing
  // on the same cycle as a commit is the value that gets committed.
  logic [CNT_W-1:0]  period_n, phase_n, burst_n;
  logic [DUTY_W-1:0] duty_n;
  logic              sync_mode_n;

  // Active registers (what the counters actually use)
  logic [CNT_W-1:0] p_act_q, w_m1_act_q, burst_act_q;

  logic [CNT_W-1:0] count_q, pcnt_q;
  ch_state_e        state_q, state_d;

  // Values derived from the staging view, used when committing
  logic [CNT_W-1:0] p_eff_n, ph_clamp_n, load_n, w_m1_n;

  logic             run_entry;
  logic             in_run, wrap, pulse_hit, last_pulse;
  logic [CNT_W-1:0] pcnt_inc;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    period_n    = period_q;
    phase_n     = phase_q;
    burst_n     = burst_q;
    duty_n      = duty_q;
    sync_mode_n = sync_mode_q;
    if (cfg_wr) begin
      case (cfg_addr)
        ADDR_PERIOD: period_n = cfg_data;
        ADDR_PHASE:  phase_n  = cfg_data;
        ADDR_CTRL: begin
          duty_n      = cfg_data[CTRL_DUTY_LSB +: DUTY_W];
          sync_mode_n = cfg_data[CTRL_SYNC_BIT];
        end
        default:     burst_n  = cfg_data;
      endcase
    end
  end

  always_comb begin
    p_eff_n    = (period_n == '0) ? DEF_PERIOD : period_n;
    ph_clamp_n = (phase_n >= p_eff_n) ? (p_eff_n - ONE) : phase_n;
    // (P - Ph) mod P: a zero phase starts right on the pulse position
    load_n     = (ph_clamp_n == '0) ? '0 : (p_eff_n - ph_clamp_n);
    w_m1_n     = width_m1(p_eff_n, duty_n);
  end

  assign in_run    = (state_q == RUN);
  assign wrap      = in_run && (count_q == p_act_q - ONE);
  assign pulse_hit = in_run && (count_q == '0);
  assign pcnt_inc  = (pulse_hit && !(&pcnt_q)) ? (pcnt_q + ONE) : pcnt_q;

  // The burst ends on the last high count of its Nth pulse; the output
  // register shows that final high cycle while the FSM sits in DONE.
  assign last_pulse = in_run && (burst_act_q != '0) &&
                      (pcnt_inc >= burst_act_q) && (count_q == w_m1_act_q);

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sync_mode_n) begin
            state_d = ARMED;
          end else begin
            state_d   = RUN;
            run_entry = 1'b1;
          end
        end
      end
      ARMED: begin
        if (sync_edge) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        if (last_pulse) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start
    if (stop) begin
      state_d   = IDLE;
      run_entry = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Staging registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q    <= '0;
      phase_q     <= '0;
      burst_q     <= '0;
      duty_q      <= '0;
      sync_mode_q <= 1'b0;
    end else begin
      period_q    <= period_n;
      phase_q     <= phase_n;
      burst_q     <= burst_n;
      duty_q      <= duty_n;
      sync_mode_q <= sync_mode_n;
    end
  end

  // -------------------------------------------------------------------------
  // Active config, counters and pulse output
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      p_act_q     <= DEF_PERIOD;
      w_m1_act_q  <= '0;
      burst_act_q <= '0;
      count_q     <= '0;
      pcnt_q      <= '0;
      ppx         <= 1'b0;
    end else begin
      if (run_entry) begin
        p_act_q     <= p_eff_n;
        w_m1_act_q  <= w_m1_n;
        burst_act_q <= burst_n;
        count_q     <= load_n;
        pcnt_q      <= '0;
      end else if (in_run) begin
        pcnt_q <= pcnt_inc;
        if (wrap) begin
          // Period boundary: the only point besides RUN entry where new
          // configuration takes effect, so a period never changes mid-way.
          count_q     <= '0;
          p_act_q     <= p_eff_n;
          w_m1_act_q  <= w_m1_n;
          burst_act_q <= burst_n;
        end else begin
          count_q <= count_q + ONE;
        end
      end
      ppx <= in_run && !stop && (count_q <= w_m1_act_q);
    end
  end

  assign busy = (state_q == ARMED) || (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef PPX_MC_STATUS_EN
  assign pulse_cnt = pcnt_q;
`endif

endmodule

// File: rtl/ppx_generator_mc.sv
// ---------------------------------------------------------------------------
// ppx_generator_mc
// NUM_CH independent pulse-per-X channels with phase offset, sync-aligned
// start, burst mode and period-boundary reconfiguration.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   cfg           configuration bus (ppx_mc_if.slave)
//   start, stop   per-channel arm/start and abort strobes
//   sync_in       external alignment pulse, rising edge used
//   ppx           registered per-channel pulse outputs
//   busy          per-channel ARMED or RUN
//   done          per-channel one-cycle burst completion strobe
//   pulse_cnt     NUM_CH*CNT_W pulse counts (only with PPX_MC_STATUS_EN)
//
// Configuration macro: PPX_MC_STATUS_EN adds the pulse_cnt status port.
// ---------------------------------------------------------------------------
module ppx_generator_mc
  import ppx_mc_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 32,
  parameter  int CLK_FREQ = 10_000_000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  ppx_mc_if.slave           cfg,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] ppx,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
`ifdef PPX_MC_STATUS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] pulse_cnt
`endif
);

  // sync_in is registered once, then compared with its delayed copy; ARMED
  // channels therefore enter RUN two cycles after sync_in rises, together.
  logic sync_q, sync_q2, sync_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q  <= sync_in;
      sync_q2 <= sync_q;
    end
  end

  assign sync_edge = sync_q && !sync_q2;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // A channel index that matches no instance is simply dropped
    logic wr_sel;
    assign wr_sel = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));

    ppx_mc_channel #(
      .CNT_W    (CNT_W),
      .CLK_FREQ (CLK_FREQ)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_wr    (wr_sel),
      .cfg_addr  (cfg.cfg_addr),
      .cfg_data  (cfg.cfg_data),
      .start     (start[i]),
      .stop      (stop[i]),
      .sync_edge (sync_edge),
      .ppx       (ppx[i]),
      .busy      (busy[i]),
      .done      (done[i])
`ifdef PPX_MC_STATUS_EN
      ,
      .pulse_cnt (pulse_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_ppx_generator_mc.sv
// ---------------------------------------------------------------------------
// tb_ppx_generator_mc
// Self-checking bench for ppx_generator_mc (NUM_CH=4, CNT_W=32, CLK_FREQ=100).
// Expected pulses (rise cycle, width) are queued per channel when a channel is
// started; a negedge monitor pops and compares them as pulses complete.
// ---------------------------------------------------------------------------
module tb_ppx_generator_mc;
  import ppx_mc_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 32;
  localparam int CLK_FREQ = 100;
  localparam int CH_W     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] start, stop;
  logic              sync_in;
  logic [NUM_CH-1:0] ppx, busy, done;

  ppx_mc_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_bus ();

  ppx_generator_mc #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg     (cfg_bus),
    .start   (start),
    .stop    (stop),
    .sync_in (sync_in),
    .ppx     (ppx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int rise;
    int width;
  } pulse_t;

  pulse_t            exp_q[NUM_CH][$];
  logic [NUM_CH-1:0] ppx_prev = '0;
  int                rise_cyc[NUM_CH];
  bit                mon_en = 1'b0;

  task automatic push(input int ch, input int rise, input int width);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    exp_q[ch].push_back(p);
  endtask

  always @(negedge clk) begin
    pulse_t e;
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ppx[c] && !ppx_prev[c]) rise_cyc[c] = cyc;
        if (!ppx[c] && ppx_prev[c]) begin
          check($sformatf("ch%0d_pulse_expected", c), longint'(exp_q[c].size() > 0), 1);
          if (exp_q[c].size() > 0) begin
            e = exp_q[c].pop_front();
            check($sformatf("ch%0d_rise", c), rise_cyc[c], e.rise);
            check($sformatf("ch%0d_width", c), cyc - rise_cyc[c], e.width);
          end
        end
      end
    end
    ppx_prev = ppx;
  end

  task automatic drained();
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("ch%0d_missing_pulses", c), exp_q[c].size(), 0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] addr, input logic [31:0] data);
    cfg_bus.cfg_wr   = 1'b1;
    cfg_bus.cfg_ch   = CH_W'(ch);
    cfg_bus.cfg_addr = addr;
    cfg_bus.cfg_data = data;
    tick();
    cfg_bus.cfg_wr   = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  task automatic pulse_stop(input logic [NUM_CH-1:0] m);
    stop = m;
    tick();
    stop = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int t, s;

  initial begin
    reset            = 1'b1;
    start            = '0;
    stop             = '0;
    sync_in          = 1'b0;
    cfg_bus.cfg_wr   = 1'b0;
    cfg_bus.cfg_ch   = '0;
    cfg_bus.cfg_addr = '0;
    cfg_bus.cfg_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ppx",  ppx,  0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // T1: default period (CLK_FREQ), single-cycle pulses, first at start+2
    t = cyc;
    push(0, t + 2, 1);
    push(0, t + 102, 1);
    push(0, t + 202, 1);
    pulse_start(4'b0001);
    @(negedge clk);
    check("t1_busy", busy[0], 1);
    wait_to(t + 250);
    pulse_stop(4'b0001);
    @(negedge clk);
    check("t1_busy_after_stop", busy[0], 0);
    drained();

    // T2: period 20, duty_log2 2 -> 5 high, phase 5 -> first rise 5 later
    cfg_write(1, ADDR_PERIOD, 32'd20);
    cfg_write(1, ADDR_CTRL,   32'd2);
    cfg_write(1, ADDR_PHASE,  32'd5);
    t = cyc;
    push(1, t + 7, 5);
    push(1, t + 27, 5);
    push(1, t + 47, 5);
    pulse_start(4'b0010);
    wait_to(t + 60);
    pulse_stop(4'b0010);
    drained();

    // T3: ch0 and ch2 sync-armed; both enter RUN 2 cycles after sync rises
    cfg_write(0, ADDR_PERIOD, 32'd16);
    cfg_write(0, ADDR_CTRL,   32'h20);
    cfg_write(2, ADDR_PERIOD, 32'd16);
    cfg_write(2, ADDR_CTRL,   32'h20);
    t = cyc;
    pulse_start(4'b0101);
    wait_to(t + 10);
    @(negedge clk);
    check("t3_busy0_armed", busy[0], 1);
    check("t3_busy2_armed", busy[2], 1);
    check("t3_ppx_armed",   ppx,     0);
    tick();
    s = cyc;
    push(0, s + 3, 1);
    push(2, s + 3, 1);
    push(0, s + 19, 1);
    push(2, s + 19, 1);
    sync_in = 1'b1;
    wait_to(s + 5);
    sync_in = 1'b0;
    wait_to(s + 30);
    pulse_stop(4'b0101);
    @(negedge clk);
    check("t3_busy_after_stop", busy, 0);
    drained();

    // T4: burst of 3 on ch3, period 10; done for exactly one cycle
    cfg_write(3, ADDR_PERIOD, 32'd10);
    cfg_write(3, ADDR_BURST,  32'd3);
    t = cyc;
    push(3, t + 2, 1);
    push(3, t + 12, 1);
    push(3, t + 22, 1);
    pulse_start(4'b1000);
    for (int k = 1; k <= 30; k++) begin
      wait_to(t + k);
      @(negedge clk);
      check("t4_done", done[3], longint'(cyc == t + 22));
      check("t4_busy", busy[3], longint'(cyc >= t + 1 && cyc <= t + 21));
    end
    drained();

    // T5: period change mid-period takes effect at the wrap; a write on the
    // wrap cycle itself is committed
    cfg_write(0, ADDR_CTRL,   32'd0);
    cfg_write(0, ADDR_PERIOD, 32'd10);
    t = cyc;
    push(0, t + 2, 1);
    push(0, t + 12, 1);
    push(0, t + 22, 1);
    push(0, t + 52, 1);
    push(0, t + 82, 1);
    push(0, t + 92, 1);
    push(0, t + 102, 1);
    pulse_start(4'b0001);
    wait_to(t + 15);
    cfg_write(0, ADDR_PERIOD, 32'd30);
    wait_to(t + 80);
    cfg_write(0, ADDR_PERIOD, 32'd10);
    wait_to(t + 110);
    pulse_stop(4'b0001);
    drained();

    // T6a: start and stop together -> stays IDLE
    t = cyc;
    start = 4'b0010;
    stop  = 4'b0010;
    tick();
    start = '0;
    stop  = '0;
    @(negedge clk);
    check("t6a_busy", busy[1], 0);
    wait_to(t + 30);
    @(negedge clk);
    check("t6a_busy_late", busy[1], 0);

    // T6b: stop mid-pulse on ch1 (5-wide pulse) truncates it to 2 cycles
    t = cyc;
    push(1, t + 7, 2);
    pulse_start(4'b0010);
    wait_to(t + 8);
    pulse_stop(4'b0010);
    @(negedge clk);
    check("t6b_ppx_after_stop",  ppx[1],  0);
    check("t6b_busy_after_stop", busy[1], 0);
    wait_to(t + 40);
    drained();

    // T6c: reset mid-run clears everything, including staging registers
    t = cyc;
    push(0, t + 2, 1);
    push(0, t + 12, 1);
    pulse_start(4'b0001);
    wait_to(t + 14);
    @(negedge clk);
    check("t6c_busy_before_reset", busy[0], 1);
    wait_to(t + 15);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6c_ppx_after_reset",  ppx,  0);
    check("t6c_busy_after_reset", busy, 0);
    check("t6c_done_after_reset", done, 0);
    wait_to(t + 40);
    drained();

    // after reset ch1 staging is back to period 0 (CLK_FREQ), duty 0, phase 0
    t = cyc;
    push(1, t + 2, 1);
    pulse_start(4'b0010);
    wait_to(t + 60);
    pulse_stop(4'b0010);
    tick();
    drained();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
